// File: rtl/mult_seq_if.sv
// Operand/result handshake bundle for mult_seq.
//   in_valid/in_ready  : operand handshake (a, b, sgn travel with it)
//   q/out_valid/out_ready : result handshake
//   busy               : operation in progress
// master = producer/consumer side, slave = multiplier side.
interface mult_seq_if #(
  parameter int unsigned WA = 8,
  parameter int unsigned WB = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [WA-1:0]     a;
  logic [WB-1:0]     b;
  logic              sgn;
  logic [WA+WB-1:0]  q;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport master (
    output in_valid, a, b, sgn, out_ready,
    input  in_ready, q, out_valid, busy
  );

  modport slave (
    input  in_valid, a, b, sgn, out_ready,
    output in_ready, q, out_valid, busy
  );
endinterface

// File: rtl/mult_seq.sv
// Multi-cycle shift-add multiplier, BPC bits of |a| retired per cycle.
// Signed operands are converted to magnitudes on capture, multiplied
// unsigned, and the sign is reapplied in a single FIX cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : mult_seq_if.slave (operand and result handshakes, busy)
module mult_seq #(
  parameter int unsigned WA  = 8,
  parameter int unsigned WB  = 8,
  parameter int unsigned BPC = 1
) (
  input  logic       clk,
  input  logic       rst,
  mult_seq_if.slave  bus
);

  localparam int unsigned N  = (WA + BPC - 1) / BPC;
  localparam int unsigned AW = N * BPC;
  localparam int unsigned PW = WA + WB;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (!(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_bpc
    $error("mult_seq: BPC must be 1, 2 or 4");
  end
  if (WA < 2 || WB < 2) begin : g_bad_width
    $error("mult_seq: WA and WB must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] a_reg;
  logic [PW-1:0] b_reg;
  logic [PW-1:0] acc;
  logic [PW-1:0] q_reg;
  logic [CW-1:0] ctr;
  logic          neg;

  logic [WA-1:0] a_mag;
  logic [WB-1:0] b_mag;
  logic [PW-1:0] pp;
  logic          accept;

  assign accept        = bus.in_valid && (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.q         = q_reg;

  // Operand magnitudes; the most negative value maps to 2^(W-1), still W bits
  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    if (bus.sgn && bus.a[WA-1]) a_mag = -bus.a;
    if (bus.sgn && bus.b[WB-1]) b_mag = -bus.b;
  end

  // Partial product for the BPC low bits of a_reg
  always_comb begin
    pp = '0;
    for (int i = 0; i < int'(BPC); i++) begin
      if (a_reg[i]) pp = pp + (b_reg << i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid)  state_nxt = CALC;
      CALC: if (ctr == '0)     state_nxt = FIX;
      FIX:                     state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Datapath; operands only enter on an accepting cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      q_reg <= '0;
      ctr   <= '0;
      neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= AW'(a_mag);
            b_reg <= PW'(b_mag);
            neg   <= bus.sgn & (bus.a[WA-1] ^ bus.b[WB-1]);
            acc   <= '0;
            ctr   <= CW'(N - 1);
          end
        end
        CALC: begin
          acc   <= acc + pp;
          a_reg <= a_reg >> BPC;
          b_reg <= b_reg << BPC;
          ctr   <= ctr - CW'(1);
        end
        FIX: q_reg <= neg ? -acc : acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: three instances with different
// width/radix choices, directed steps followed by randomized traffic
// compared against an arithmetic reference.
module tb_mult_seq;

  logic clk;
  logic rst;

  mult_seq_if #(.WA(8),  .WB(8)) if0 ();
  mult_seq_if #(.WA(12), .WB(6)) if1 ();
  mult_seq_if #(.WA(7),  .WB(5)) if2 ();

  mult_seq #(.WA(8),  .WB(8), .BPC(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  mult_seq #(.WA(12), .WB(6), .BPC(4)) u1 (.clk(clk), .rst(rst), .bus(if1));
  mult_seq #(.WA(7),  .WB(5), .BPC(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Per-instance geometry
  function automatic int wa_of(input int d);
    case (d) 0: return 8; 1: return 12; default: return 7; endcase
  endfunction
  function automatic int wb_of(input int d);
    case (d) 0: return 8; 1: return 6; default: return 5; endcase
  endfunction
  function automatic int n_of(input int d);
    case (d) 0: return 8; 1: return 3; default: return 4; endcase
  endfunction

  // Reference: interpret operands, multiply, keep WA+WB bits
  function automatic logic [31:0] ref_q(input int d, input logic [15:0] a,
                                       input logic [15:0] b, input logic s);
    int     wa = wa_of(d);
    int     wb = wb_of(d);
    longint av, bv, p;
    av = longint'(a) & ((64'sd1 <<< wa) - 1);
    bv = longint'(b) & ((64'sd1 <<< wb) - 1);
    if (s && a[wa-1]) av = av - (64'sd1 <<< wa);
    if (s && b[wb-1]) bv = bv - (64'sd1 <<< wb);
    p = av * bv;
    return 32'(p & ((64'sd1 <<< (wa + wb)) - 1));
  endfunction

  task automatic set_in(input int d, input logic v, input logic [15:0] a,
                        input logic [15:0] b, input logic s);
    case (d)
      0: begin if0.in_valid = v; if0.a = 8'(a);  if0.b = 8'(b); if0.sgn = s; end
      1: begin if1.in_valid = v; if1.a = 12'(a); if1.b = 6'(b); if1.sgn = s; end
      default: begin if2.in_valid = v; if2.a = 7'(a); if2.b = 5'(b); if2.sgn = s; end
    endcase
  endtask

  task automatic set_ordy(input int d, input logic r);
    case (d)
      0: if0.out_ready = r;
      1: if1.out_ready = r;
      default: if2.out_ready = r;
    endcase
  endtask

  function automatic logic [31:0] q_of(input int d);
    case (d) 0: return 32'(if0.q); 1: return 32'(if1.q); default: return 32'(if2.q); endcase
  endfunction
  function automatic logic ov_of(input int d);
    case (d) 0: return if0.out_valid; 1: return if1.out_valid; default: return if2.out_valid; endcase
  endfunction
  function automatic logic ir_of(input int d);
    case (d) 0: return if0.in_ready; 1: return if1.in_ready; default: return if2.in_ready; endcase
  endfunction
  function automatic logic busy_of(input int d);
    case (d) 0: return if0.busy; 1: return if1.busy; default: return if2.busy; endcase
  endfunction

  // Issue one op with out_ready low and wait for out_valid. Edges are
  // counted with the accepting edge as edge 1.
  task automatic op(input int d, input logic [15:0] a, input logic [15:0] b,
                    input logic s, input string tag);
    logic [31:0] exp;
    int          cnt;
    logic        busy_ok;
    exp     = ref_q(d, a, b, s);
    busy_ok = 1'b1;
    set_ordy(d, 1'b0);
    set_in(d, 1'b1, a, b, s);
    chk({tag, "_in_ready"}, 32'(ir_of(d)), 32'd1);
    step();
    set_in(d, 1'b0, 16'h0, 16'h0, 1'b0);
    cnt = 1;
    while (!ov_of(d) && cnt < 64) begin
      if (!busy_of(d)) busy_ok = 1'b0;
      step();
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'(n_of(d) + 2));
    chk({tag, "_busy"}, 32'(busy_ok && busy_of(d)), 32'd1);
    chk({tag, "_q"}, q_of(d), exp);
  endtask

  task automatic handshake(input int d, input string tag);
    set_ordy(d, 1'b1);
    step();
    set_ordy(d, 1'b0);
    chk({tag, "_ov_drop"}, 32'(ov_of(d)), 32'd0);
    chk({tag, "_idle_ir"}, 32'(ir_of(d)), 32'd1);
  endtask

  // Random traffic with random backpressure and a scoreboard queue
  task automatic rand_run(input int d, input int nops);
    logic [31:0] sb[$];
    int          acc_n, done_n, cyc;
    logic        v, s, r;
    logic [15:0] a, b;
    acc_n = 0; done_n = 0; cyc = 0;
    while (done_n < nops && cyc < nops * 40) begin
      v = ($urandom_range(0, 3) != 0) && (acc_n < nops);
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'h0;
      if ($urandom_range(0, 7) == 0) b = 16'hFFFF;
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      set_in(d, v, a, b, s);
      set_ordy(d, r);
      if (ov_of(d) && r) begin
        chk("rand_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) chk("rand_q", q_of(d), sb.pop_front());
        done_n++;
      end
      if (v && ir_of(d)) begin
        sb.push_back(ref_q(d, a, b, s));
        acc_n++;
      end
      step();
      cyc++;
    end
    set_in(d, 1'b0, 16'h0, 16'h0, 1'b0);
    set_ordy(d, 1'b0);
    chk("rand_done", 32'(done_n), 32'(nops));
    chk("rand_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] q_hold;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      set_in(d, 1'b0, 16'h0, 16'h0, 1'b0);
      set_ordy(d, 1'b0);
    end
    step();
    step();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_q", q_of(d), 32'd0);
      chk("rst_ov", 32'(ov_of(d)), 32'd0);
      chk("rst_ir", 32'(ir_of(d)), 32'd1);
      chk("rst_busy", 32'(busy_of(d)), 32'd0);
    end

    // Unsigned 8x8
    op(0, 16'd200, 16'd150, 1'b0, "t1");
    chk("t1_const", q_of(0), 32'h7530);
    handshake(0, "t1");

    // Signed corners and the same bits unsigned
    op(0, 16'h80, 16'h7F, 1'b1, "t2a");
    chk("t2a_const", q_of(0), 32'hC080);
    handshake(0, "t2a");
    op(0, 16'hFF, 16'hFF, 1'b1, "t2b");
    chk("t2b_const", q_of(0), 32'h0001);
    handshake(0, "t2b");
    op(0, 16'hFF, 16'hFF, 1'b0, "t2c");
    chk("t2c_const", q_of(0), 32'hFE01);
    handshake(0, "t2c");

    // Backpressure in DONE; in_valid pulses must be ignored
    op(0, 16'd77, 16'd201, 1'b0, "t3");
    q_hold = q_of(0);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1'(i % 2 == 0), 16'd3, 16'd3, 1'b0);
      step();
      chk("t3_q_stable", q_of(0), q_hold);
      chk("t3_ov_held", 32'(ov_of(0)), 32'd1);
      chk("t3_ir_low", 32'(ir_of(0)), 32'd0);
    end
    set_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    handshake(0, "t3");
    chk("t3_q_kept", q_of(0), q_hold);
    for (int i = 0; i < 12; i++) step();
    chk("t3_no_queued_op", 32'(ov_of(0)), 32'd0);

    // Reset during the third CALC cycle discards the operation
    set_in(0, 1'b1, 16'd100, 16'd100, 1'b0);
    step();
    set_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_q", q_of(0), 32'd0);
    chk("t4_ov", 32'(ov_of(0)), 32'd0);
    chk("t4_ir", 32'(ir_of(0)), 32'd1);
    chk("t4_busy", 32'(busy_of(0)), 32'd0);
    for (int i = 0; i < 12; i++) step();
    chk("t4_no_output", 32'(ov_of(0)), 32'd0);
    op(0, 16'd3, 16'd5, 1'b0, "t4b");
    chk("t4b_const", q_of(0), 32'd15);
    handshake(0, "t4b");

    // 12x6, radix 16
    op(1, 16'hFFF, 16'h3F, 1'b0, "t5a");
    chk("t5a_const", q_of(1), 32'h3EFC1);
    handshake(1, "t5a");
    op(1, 16'h800, 16'h20, 1'b1, "t5b");
    chk("t5b_const", q_of(1), 32'h10000);
    handshake(1, "t5b");

    // 7x5, radix 4 with a padded final digit
    op(2, 16'h40, 16'h10, 1'b1, "t5c");
    chk("t5c_const", q_of(2), 32'h400);
    handshake(2, "t5c");

    // Zero with a negative partner gives plain zero
    op(0, 16'h0, 16'h80, 1'b1, "t6");
    chk("t6_const", q_of(0), 32'd0);
    handshake(0, "t6");

    rand_run(0, 1000);
    rand_run(1, 300);
    rand_run(2, 300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
